// File: rtl/piano_pkg.sv
// piano_pkg -- shared definitions for the poly_piano tone generator.
//   MAX_KEYS     : largest supported voice count
//   TUNE         : per-voice phase increment (24-bit accumulator scale)
//   state_e      : frame sequencer states
//   clog2        : ceil(log2(v)), 0 for v <= 1
//   sine_entry   : elaboration-time sine table generator for wave_rom
package piano_pkg;

    localparam int MAX_KEYS = 16;
    localparam int TUNE_W   = 24;

    // Phase increment added once per output sample for each voice.
    localparam logic [TUNE_W-1:0] TUNE [0:MAX_KEYS-1] = '{
        24'h400000, 24'h200000, 24'h600000, 24'hA00000,
        24'hC00000, 24'hE00000, 24'h800000, 24'h100000,
        24'h300000, 24'h500000, 24'h700000, 24'h900000,
        24'hB00000, 24'hD00000, 24'hF00000, 24'h080000
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SCAN,
        ST_DRAIN,
        ST_NORM,
        ST_OUT
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // pi/2 in Q30 fixed point.
    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    // Offset-binary sine sample idx of a 2^aw-entry table, ww bits wide.
    // Quarter-wave symmetry keeps the Taylor series on [0, pi/2], so the
    // peaks land exactly on MID +/- (MID-1) and zero crossings on MID.
    function automatic logic [31:0] sine_entry(input longint idx,
                                               input longint aw,
                                               input longint ww);
        longint q, m, x, term, acc, amp, mid;
        logic   neg;
        q   = longint'(1) << (aw - 2);
        mid = longint'(1) << (ww - 1);
        neg = 1'b0;
        if (idx <= q) begin
            m = idx;
        end else if (idx <= q + q) begin
            m = q + q - idx;
        end else if (idx <= q + q + q) begin
            m   = idx - q - q;
            neg = 1'b1;
        end else begin
            m   = (q << 2) - idx;
            neg = 1'b1;
        end
        x    = (HALF_PI_Q30 * m) / q;
        acc  = x;
        term = x;
        for (longint k = 1; k <= 7; k++) begin
            term = -((((term * x) >>> 30) * x) >>> 30) / ((k + k) * (k + k + 1));
            acc  = acc + term;
        end
        amp = ((mid - 1) * acc + (longint'(1) << 29)) >>> 30;
        return neg ? 32'(mid - amp) : 32'(mid + amp);
    endfunction

endpackage

// File: rtl/wave_rom.sv
// wave_rom -- one-period sine wavetable, offset-binary, registered read.
//   clk     : clock
//   addr_i  : table index (ROM_AW bits)
//   data_o  : sample at addr_i from the previous cycle (1-cycle latency)
module wave_rom
    import piano_pkg::*;
#(
    parameter int ROM_AW = 8,
    parameter int WAVE_W = 8
) (
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr_i,
    output logic [WAVE_W-1:0] data_o
);

    localparam int DEPTH = 1 << ROM_AW;

    logic [WAVE_W-1:0] rom_tbl [DEPTH];
    logic [WAVE_W-1:0] data_q;

    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_tbl
        localparam logic [31:0] ENTRY = sine_entry(longint'(gi), longint'(ROM_AW), longint'(WAVE_W));
        assign rom_tbl[gi] = ENTRY[WAVE_W-1:0];
    end

    always_ff @(posedge clk) begin
        data_q <= rom_tbl[addr_i];
    end

    assign data_o = data_q;

endmodule

// File: rtl/poly_piano.sv
// poly_piano -- time-multiplexed polyphonic tone generator.
//   clk          : clock
//   rst          : asynchronous active-high reset
//   keys         : raw key levels (asynchronous), 1 = pressed
//   wave_out     : mixed offset-binary sample, held between updates
//   sample_valid : one-cycle pulse when wave_out updates
//   active_cnt   : number of voices sounding in the current sample
// One frame per SAMPLE_DIV clocks: snapshot keys, scan each voice through
// the shared wavetable, sum active voices, normalise by ceil(log2(count)).
module poly_piano
    import piano_pkg::*;
#(
    parameter int NUM_KEYS   = 8,
    parameter int ACC_W      = 24,
    parameter int WAVE_W     = 8,
    parameter int ROM_AW     = 8,
    parameter int SAMPLE_DIV = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_KEYS-1:0]            keys,
    output logic [WAVE_W-1:0]              wave_out,
    output logic                           sample_valid,
    output logic [clog2(NUM_KEYS+1)-1:0]   active_cnt
);

    localparam int CNT_W = clog2(NUM_KEYS + 1);
    localparam int KW    = (NUM_KEYS > 1) ? clog2(NUM_KEYS) : 1;
    localparam int SUM_W = WAVE_W + clog2(NUM_KEYS) + 1;
    localparam int DIV_W = (SAMPLE_DIV > 1) ? clog2(SAMPLE_DIV) : 1;
    localparam logic [WAVE_W-1:0] MID = {1'b1, {(WAVE_W-1){1'b0}}};

    state_e                    state_q, state_d;
    logic [NUM_KEYS-1:0]       sync1_q, sync2_q, snap_q, snap_d;
    logic [DIV_W-1:0]          div_q;
    logic [KW-1:0]             k_q, k_d;
    logic                      act_q, act_d;
    logic signed [SUM_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]          count_q, count_d, pop_cnt;
    logic [WAVE_W-1:0]         wave_q, wave_d;
    logic                      valid_q, valid_d;
    logic [CNT_W-1:0]          cnt_out_q, cnt_out_d;
    logic [ACC_W-1:0]          phase_q [NUM_KEYS];
    logic [ACC_W-1:0]          tune_w  [NUM_KEYS];
    logic [ROM_AW-1:0]         rom_addr;
    logic [WAVE_W-1:0]         rom_data;
    logic [WAVE_W-1:0]         smp_signed;
    logic                      tick;
    int                        shift;

    // Rescale the 24-bit tuning words to the accumulator width so pitch
    // is independent of ACC_W.
    genvar gi;
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_tune
        if (ACC_W >= TUNE_W) begin : g_wide
            assign tune_w[gi] = ACC_W'(TUNE[gi]) << (ACC_W - TUNE_W);
        end else begin : g_narrow
            assign tune_w[gi] = ACC_W'(TUNE[gi] >> (TUNE_W - ACC_W));
        end
    end

    assign tick     = (div_q == DIV_W'(SAMPLE_DIV - 1));
    assign rom_addr = phase_q[k_q][ACC_W-1 -: ROM_AW];

    wave_rom #(
        .ROM_AW (ROM_AW),
        .WAVE_W (WAVE_W)
    ) u_rom (
        .clk    (clk),
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    // Offset-binary to two's complement: s - MID is just an MSB flip.
    assign smp_signed = {~rom_data[WAVE_W-1], rom_data[WAVE_W-2:0]};

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            pop_cnt = pop_cnt + CNT_W'(sync2_q[i]);
        end
    end

    // ceil(log2(count)); 0 for count <= 1.
    always_comb begin
        shift = 0;
        for (int i = 0; i < CNT_W; i++) begin
            if (int'(count_q) > (1 << i)) shift = i + 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        act_d     = 1'b0;
        sum_d     = sum_q;
        count_d   = count_q;
        snap_d    = snap_q;
        wave_d    = wave_q;
        valid_d   = 1'b0;
        cnt_out_d = cnt_out_q;

        // ROM data trails the scan index by one cycle; act_q marks whether
        // the returning sample belongs to a sounding voice.
        if (act_q) begin
            sum_d = sum_q + $signed({{(SUM_W-WAVE_W){smp_signed[WAVE_W-1]}}, smp_signed});
        end

        case (state_q)
            ST_IDLE: begin
                if (tick) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                snap_d  = sync2_q;
                sum_d   = '0;
                count_d = pop_cnt;
                k_d     = '0;
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                act_d = snap_q[k_q];
                k_d   = k_q + 1'b1;
                if (k_q == KW'(NUM_KEYS - 1)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_d = ST_NORM;
            end
            ST_NORM: begin
                // |sum >>> shift| always fits WAVE_W signed, so truncation is exact.
                wave_d    = WAVE_W'(sum_q >>> shift) ^ MID;
                valid_d   = 1'b1;
                cnt_out_d = count_q;
                state_d   = ST_OUT;
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            snap_q    <= '0;
            div_q     <= '0;
            k_q       <= '0;
            act_q     <= 1'b0;
            sum_q     <= '0;
            count_q   <= '0;
            wave_q    <= MID;
            valid_q   <= 1'b0;
            cnt_out_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                phase_q[i] <= '0;
            end
        end else begin
            sync1_q   <= keys;
            sync2_q   <= sync1_q;
            snap_q    <= snap_d;
            div_q     <= tick ? '0 : div_q + 1'b1;
            k_q       <= k_d;
            act_q     <= act_d;
            sum_q     <= sum_d;
            count_q   <= count_d;
            wave_q    <= wave_d;
            valid_q   <= valid_d;
            cnt_out_q <= cnt_out_d;
            // Released voices park at phase 0 so a new press starts at ROM[0].
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (state_q == ST_SCAN && int'(k_q) == i) begin
                    phase_q[i] <= snap_q[i] ? phase_q[i] + tune_w[i] : '0;
                end
            end
        end
    end

    assign wave_out     = wave_q;
    assign sample_valid = valid_q;
    assign active_cnt   = cnt_out_q;

endmodule

// File: tb/tb_poly_piano.sv
// tb_poly_piano -- directed self-checking bench for poly_piano
// (NUM_KEYS = 8, SAMPLE_DIV = 16, 8-bit samples, 256-entry table).
module tb_poly_piano;

    localparam int NK  = 8;
    localparam int DIV = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] keys = '0;
    logic [7:0]    wave_out;
    logic          sample_valid;
    logic [3:0]    active_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    poly_piano #(
        .NUM_KEYS   (NK),
        .ACC_W      (24),
        .WAVE_W     (8),
        .ROM_AW     (8),
        .SAMPLE_DIV (DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .keys         (keys),
        .wave_out     (wave_out),
        .sample_valid (sample_valid),
        .active_cnt   (active_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Counts negedges until sample_valid is seen (bounded).
    task automatic wait_sample(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_valid && n < 100);
        check_eq("sample_valid seen", {31'd0, sample_valid}, 32'd1);
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] wave, input logic [3:0] cnt);
        int n;
        wait_sample(n);
        check_eq({tag, " wave"}, {24'd0, wave_out}, {24'd0, wave});
        check_eq({tag, " cnt"}, {28'd0, active_cnt}, {28'd0, cnt});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hits;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("reset wave", {24'd0, wave_out}, 32'h80);
        check_eq("reset valid", {31'd0, sample_valid}, 32'd0);
        check_eq("reset cnt", {28'd0, active_cnt}, 32'd0);
        rst = 1'b0;

        // No keys: first pulse latency and period
        wait_sample(n);
        check_eq("first pulse latency", n, DIV - 1 + NK + 4);
        check_eq("idle wave", {24'd0, wave_out}, 32'h80);
        check_eq("idle cnt", {28'd0, active_cnt}, 32'd0);
        wait_sample(n);
        check_eq("pulse period", n, DIV);
        @(negedge clk);
        check_eq("pulse width", {31'd0, sample_valid}, 32'd0);

        // Single voice: steps a quarter table per sample
        keys = 8'h01;
        expect_frame("k0 n0", 8'h80, 4'd1);
        expect_frame("k0 n1", 8'hFF, 4'd1);
        expect_frame("k0 n2", 8'h80, 4'd1);
        expect_frame("k0 n3", 8'h01, 4'd1);
        expect_frame("k0 n4", 8'h80, 4'd1);
        keys = 8'h00;
        expect_frame("rel all", 8'h80, 4'd0);

        // Two voices, shift 1 (includes a negative sum)
        keys = 8'h03;
        expect_frame("k01 n0", 8'h80, 4'd2);
        expect_frame("k01 n1", 8'hEC, 4'd2);
        expect_frame("k01 n2", 8'hBF, 4'd2);
        expect_frame("k01 n3", 8'h6D, 4'd2);
        keys = 8'h00;
        expect_frame("rel 01", 8'h80, 4'd0);

        // All eight voices, then release key 3
        keys = 8'hFF;
        expect_frame("all n0", 8'h80, 4'd8);
        expect_frame("all n1", 8'h86, 4'd8);
        keys = 8'hF7;
        expect_frame("rel k3", 8'h7B, 4'd7);
        check_eq("phase3 cleared", dut.phase_q[3], 32'd0);
        keys = 8'h00;
        expect_frame("rel rest", 8'h80, 4'd0);

        // One-clock glitch away from LATCH is ignored
        @(negedge clk);
        keys = 8'h01;
        @(negedge clk);
        keys = 8'h00;
        expect_frame("glitch", 8'h80, 4'd0);

        // Press during SCAN takes effect only next frame
        repeat (7) @(negedge clk);
        keys = 8'h01;
        expect_frame("midscan same", 8'h80, 4'd0);
        expect_frame("midscan next", 8'h80, 4'd1);
        expect_frame("midscan n1", 8'hFF, 4'd1);

        // Asynchronous reset during SCAN
        repeat (7) @(negedge clk);
        check_eq("pre-rst cnt", {28'd0, active_cnt}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst wave", {24'd0, wave_out}, 32'h80);
        check_eq("rst valid", {31'd0, sample_valid}, 32'd0);
        check_eq("rst cnt", {28'd0, active_cnt}, 32'd0);
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sample_valid) hits++;
        end
        check_eq("no pulse in reset", hits, 0);
        rst = 1'b0;
        wait_sample(n);
        check_eq("post-rst latency", n, DIV - 1 + NK + 4);
        check_eq("post-rst wave", {24'd0, wave_out}, 32'h80);
        check_eq("post-rst cnt", {28'd0, active_cnt}, 32'd1);
        expect_frame("post-rst n1", 8'hFF, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
